// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard controller.
package hazard_pkg;

  localparam int HZ_REG_W    = 5;
  localparam int HZ_ZERO_REG = 31;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic                load;
    logic [HZ_REG_W-1:0] rd;
  } stage_info_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side request fields and hazard control/forwarding outputs.
interface hazard_controller_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rd;
  logic             id_reg_write;
  logic             id_is_load;
  logic             ex_br_taken;
  logic             stall_pc;
  logic             bubble_ex;
  logic             flush_ifid;
  logic             fwd_alu;
  logic             fwd_mem;
  logic [REG_W-1:0] rd_alu;
  logic [REG_W-1:0] rd_mem;

  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
           id_reg_write, id_is_load, ex_br_taken,
    input  stall_pc, bubble_ex, flush_ifid, fwd_alu, fwd_mem, rd_alu, rd_mem
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
           id_reg_write, id_is_load, ex_br_taken,
    output stall_pc, bubble_ex, flush_ifid, fwd_alu, fwd_mem, rd_alu, rd_mem
  );
endinterface

// File: rtl/hazard_controller_dep_match.sv
// Combinational check of up to three used decode sources against one stage destination.
module dep_match
  import hazard_pkg::*;
#(
  parameter int REG_W    = HZ_REG_W,
  parameter int ZERO_REG = HZ_ZERO_REG
) (
  input  stage_info_t      stage,
  input  logic [REG_W-1:0] rn,
  input  logic [REG_W-1:0] rm,
  input  logic [REG_W-1:0] rd,
  input  logic             use_rn,
  input  logic             use_rm,
  input  logic             use_rd,
  output logic             hit
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic any_src;

  assign any_src = (use_rn & (rn == stage.rd)) |
                   (use_rm & (rm == stage.rd)) |
                   (use_rd & (rd == stage.rd));

  // XZR reads are constant zero, so a write to it never creates a dependency
  assign hit = stage.valid & (stage.rd != ZR) & any_src;
endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, branch flush and forwarding-enable generation beside decode.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
//
// state | meaning
// RUN   | normal issue; a load-use hit stalls this cycle and enters HOLD
// HOLD  | extra stall cycles while cnt != 0; cnt == 0 is the release cycle
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = HZ_REG_W,
  parameter int LOAD_STALLS = 1,
  parameter int ZERO_REG    = HZ_ZERO_REG
) (
  input  logic clk,
  input  logic reset,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes,
`endif
  hazard_controller_if.slave hz
);
  localparam logic [REG_W-1:0] ZR       = REG_W'(ZERO_REG);
  localparam logic [2:0]       CNT_INIT = 3'(LOAD_STALLS - 1);

  stage_info_t ex_q, mem_q, id_info;
  hz_state_e   state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        src_hit, hit, stall, bubble, flush;

  assign id_info = '{valid: hz.id_valid, wr: hz.id_reg_write,
                     load: hz.id_is_load, rd: hz.id_rd};

  dep_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_dep (
    .stage  (ex_q),
    .rn     (hz.id_rn),
    .rm     (hz.id_rm),
    .rd     (hz.id_rd),
    .use_rn (hz.id_use_rn),
    .use_rm (hz.id_use_rm),
    .use_rd (hz.id_use_rd),
    .hit    (src_hit)
  );

  assign hit = hz.id_valid & ex_q.load & src_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mem_q <= ex_q;
      ex_q  <= bubble ? '0 : id_info;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (reset) begin
      state_n = RUN;
      cnt_n   = '0;
    end else if (hz.ex_br_taken) begin
      // the dependent instruction is on the wrong path, so there is nothing to wait for
      flush   = 1'b1;
      bubble  = 1'b1;
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      case (state)
        RUN: begin
          if (hit) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_n = HOLD;
            cnt_n   = CNT_INIT;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state_n = RUN;
          end else begin
            stall  = 1'b1;
            bubble = 1'b1;
            cnt_n  = cnt - 3'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign hz.stall_pc   = stall;
  assign hz.bubble_ex  = bubble;
  assign hz.flush_ifid = flush;
  assign hz.fwd_alu    = ~reset & ex_q.valid & ex_q.wr & ~ex_q.load & (ex_q.rd != ZR);
  assign hz.fwd_mem    = ~reset & mem_q.valid & mem_q.wr & (mem_q.rd != ZR);
  assign hz.rd_alu     = reset ? '0 : ex_q.rd;
  assign hz.rd_mem     = reset ? '0 : mem_q.rd;

`ifdef HAZARD_PERF_EN
  logic [31:0] stalls_q, flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (stall && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
      if (flush && (flushes_q != '1)) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_stalls  = reset ? '0 : stalls_q;
  assign perf_flushes = reset ? '0 : flushes_q;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: two controllers (1 and 3 load stalls) share random decode traffic.
module tb_hazard_controller;
  import hazard_pkg::*;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        fa;
    logic        fm;
    logic [4:0]  rda;
    logic [4:0]  rdm;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } sh_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_W(5)) if1 ();
  hazard_controller_if #(.REG_W(5)) if3 ();

  logic [31:0] ps1, pf1, ps3, pf3;

`ifdef HAZARD_PERF_EN
  hazard_controller #(.REG_W(5), .LOAD_STALLS(1), .ZERO_REG(31)) u1 (
    .clk(clk), .reset(reset), .perf_stalls(ps1), .perf_flushes(pf1), .hz(if1));
  hazard_controller #(.REG_W(5), .LOAD_STALLS(3), .ZERO_REG(31)) u3 (
    .clk(clk), .reset(reset), .perf_stalls(ps3), .perf_flushes(pf3), .hz(if3));
`else
  hazard_controller #(.REG_W(5), .LOAD_STALLS(1), .ZERO_REG(31)) u1 (
    .clk(clk), .reset(reset), .hz(if1));
  hazard_controller #(.REG_W(5), .LOAD_STALLS(3), .ZERO_REG(31)) u3 (
    .clk(clk), .reset(reset), .hz(if3));
  assign ps1 = '0;
  assign pf1 = '0;
  assign ps3 = '0;
  assign pf3 = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q3[$];

  logic       i_idv, i_urn, i_urm, i_urd, i_rw, i_ld, i_br;
  logic [4:0] i_rn, i_rm, i_rd;

  // reference state: what sits in EX and MEM, and how many cycles of the
  // post-hit window remain (stall cycles still owed plus one release cycle)
  sh_t         m_ex[2];
  sh_t         m_mem[2];
  int          m_win[2];
  logic [31:0] m_ps[2];
  logic [31:0] m_pf[2];

  task automatic model(input int k, input int stalls, output exp_t e);
    sh_t  ex, mem;
    logic src, hit;
    e = '0;
    if (reset) begin
      m_ex[k]  = '0;
      m_mem[k] = '0;
      m_win[k] = 0;
      m_ps[k]  = '0;
      m_pf[k]  = '0;
      return;
    end
    ex  = m_ex[k];
    mem = m_mem[k];
    e.fa  = ex.v && ex.wr && !ex.ld && ex.rd != 5'd31;
    e.fm  = mem.v && mem.wr && mem.rd != 5'd31;
    e.rda = ex.rd;
    e.rdm = mem.rd;
`ifdef HAZARD_PERF_EN
    e.ps = m_ps[k];
    e.pf = m_pf[k];
`endif
    src = (i_urn && i_rn == ex.rd) || (i_urm && i_rm == ex.rd) || (i_urd && i_rd == ex.rd);
    hit = i_idv && ex.v && ex.ld && ex.rd != 5'd31 && src;
    if (i_br) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
      m_win[k] = 0;
    end else if (m_win[k] > 0) begin
      e.stall  = (m_win[k] > 1);
      e.bubble = e.stall;
      m_win[k] = m_win[k] - 1;
    end else if (hit) begin
      e.stall  = 1'b1;
      e.bubble = 1'b1;
      m_win[k] = stalls;
    end
    if (e.stall && m_ps[k] != 32'hFFFF_FFFF) m_ps[k] = m_ps[k] + 1;
    if (e.flush && m_pf[k] != 32'hFFFF_FFFF) m_pf[k] = m_pf[k] + 1;
    m_mem[k] = ex;
    m_ex[k]  = e.bubble ? '0 : {i_idv, i_rw, i_ld, i_rd};
  endtask

  task automatic set_i(input logic idv, input logic [4:0] rn, rm, rd,
                       input logic urn, urm, urd, rw, ld, br);
    i_idv = idv; i_rn = rn; i_rm = rm; i_rd = rd;
    i_urn = urn; i_urm = urm; i_urd = urd;
    i_rw = rw; i_ld = ld; i_br = br;
  endtask

  task automatic step();
    exp_t e1, e3;
    if1.id_valid = i_idv; if1.id_rn = i_rn; if1.id_rm = i_rm; if1.id_rd = i_rd;
    if1.id_use_rn = i_urn; if1.id_use_rm = i_urm; if1.id_use_rd = i_urd;
    if1.id_reg_write = i_rw; if1.id_is_load = i_ld; if1.ex_br_taken = i_br;
    if3.id_valid = i_idv; if3.id_rn = i_rn; if3.id_rm = i_rm; if3.id_rd = i_rd;
    if3.id_use_rn = i_urn; if3.id_use_rm = i_urm; if3.id_use_rd = i_urd;
    if3.id_reg_write = i_rw; if3.id_is_load = i_ld; if3.ex_br_taken = i_br;
    model(0, 1, e1);
    model(1, 3, e3);
    q1.push_back(e1);
    q3.push_back(e3);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int j = 0; j < n; j++) begin
      set_i(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  always @(negedge clk) begin
    exp_t got, e;
    if (q1.size() > 0) begin
      e   = q1.pop_front();
      got = {if1.stall_pc, if1.bubble_ex, if1.flush_ifid, if1.fwd_alu, if1.fwd_mem,
             if1.rd_alu, if1.rd_mem, ps1, pf1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ls1 cyc %0d got %h exp %h", cyc, got, e);
      end
    end
    if (q3.size() > 0) begin
      e   = q3.pop_front();
      got = {if3.stall_pc, if3.bubble_ex, if3.flush_ifid, if3.fwd_alu, if3.fwd_mem,
             if3.rd_alu, if3.rd_mem, ps3, pf3};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ls3 cyc %0d got %h exp %h", cyc, got, e);
      end
    end
  end

  initial begin
    set_i(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    nop(2);

    // LDUR X2 ; ADD X3,X2,X4 held while stalled
    set_i(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step();
    set_i(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) step();
    nop(2);

    // ADD X1 ; SUB X5,X1,X6
    set_i(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    set_i(1'b1, 5'd1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    nop(2);

    // LDUR X31 ; ADD X3,X31,X4
    set_i(1'b1, 5'd1, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step();
    set_i(1'b1, 5'd31, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    nop(2);

    // load-use coinciding with a taken branch
    set_i(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step();
    set_i(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); step();
    nop(2);

    // STUR-style use of rd as a source, then reset in the middle of the hold
    set_i(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step();
    set_i(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    step();
    reset = 1'b1; step();
    reset = 1'b0; step();
    nop(2);

    for (int n = 0; n < 600; n++) begin
      set_i(($urandom_range(0, 99) < 85), pick_reg(), pick_reg(), pick_reg(),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 99) < 8));
      reset = ($urandom_range(0, 99) < 2);
      step();
    end
    reset = 1'b0;
    nop(2);

    @(negedge clk);
    #1;
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d/%0d required 0", q1.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
